cr_huf_comp_lut_long: RTL
=========================

Name: cr_huf_comp_lut_long

Overview:
- Downstream consumer of the long-symbol table builder's LUT write interface: a double-buffered (ping-pong) code LUT.
- The builder streams per-symbol code/length entries into the fill bank and commits the bank with a wr_done write.
- The encoder then looks up codes from the committed bank, one table per block, in commit order.
- Provides lut_st_full backpressure to the builder when both banks hold uncommitted-to-encoder tables.

Parameters:
- DEPTH, 249, entries per bank (max long-symbol table depth).
- ADDR_W, 8, symbol address width; must satisfy 2^ADDR_W >= DEPTH.
- DATA_W, 20, entry width (code bits plus code length).
- SEQ_W, 4, table sequence-id width.
- SIZE_W, 20, table size field width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- st_lut_wr  in  1  entry write strobe from the builder.
- st_lut_wr_addr  in  ADDR_W  symbol address.
- st_lut_wr_data  in  DATA_W  entry data.
- st_lut_wr_done  in  1  qualifies st_lut_wr; this is the last write, so commit the bank.
- st_lut_seq_id  in  SEQ_W  table sequence id, sampled at commit.
- st_lut_st_size  in  SIZE_W  table size, sampled at commit.
- lut_st_full  out  1  both banks committed; builder must not write.
- enc_lut_rd  in  1  lookup request.
- enc_lut_rd_addr  in  ADDR_W  lookup symbol.
- enc_lut_tbl_done  in  1  encoder finished with the current table; release its bank.
- lut_enc_rd_vld  out  1  lookup data valid.
- lut_enc_rd_data  out  DATA_W  lookup data.
- lut_enc_tbl_vld  out  1  a committed table is available to read.
- lut_enc_seq_id  out  SEQ_W  seq id of the current read table.
- lut_enc_st_size  out  SIZE_W  size of the current read table.
- lut_wr_ovfl_err  out  1  sticky: write arrived while full, or wr_addr >= DEPTH.
- lut_rd_err  out  1  one-cycle pulse: enc_lut_rd with no valid table, or rd_addr >= DEPTH.

Behaviour:
- All state resets asynchronously.
- Output reset values: all outputs 0; wr_bank = 0, rd_bank = 0, tbl_cnt = 0.
- Storage is 2 x DEPTH registers, indexed {bank, addr}. Entry contents are not reset.
- tbl_cnt (0..2) is the number of committed, unreleased tables.
  - lut_st_full = (tbl_cnt == 2).
  - lut_enc_tbl_vld = (tbl_cnt != 0).
- Write path:
  - When st_lut_wr & !full & addr < DEPTH, the entry is written to {wr_bank, addr}.
  - If wr_done is also asserted: latch seq_id/st_size into the wr_bank meta registers, toggle wr_bank, and increment tbl_cnt.
  - A write while full, or with an out-of-range address, is dropped and lut_wr_ovfl_err is set. The error clears only on reset.
  - A dropped wr_done does not commit.
- Read path:
  - When enc_lut_rd & tbl_vld & addr < DEPTH, lut_enc_rd_data holds {rd_bank, addr} contents with lut_enc_rd_vld = 1 the next cycle (latency 1). Data is held until the next valid read.
  - Otherwise rd_vld = 0 next cycle and lut_rd_err pulses.
  - lut_enc_seq_id and lut_enc_st_size reflect the rd_bank meta registers whenever tbl_vld = 1, and are 0 otherwise.
- Release:
  - When enc_lut_tbl_done & tbl_vld: toggle rd_bank and decrement tbl_cnt.
  - enc_lut_tbl_done with tbl_cnt == 0 is ignored.
- Simultaneous commit and release in the same cycle: tbl_cnt is unchanged, and both pointers toggle.
  - This is legal at tbl_cnt = 1 only; at tbl_cnt = 2 the commit is dropped because full is evaluated on the registered count.
- A read and a release in the same cycle: the read uses the pre-toggle rd_bank.
- A write to the fill bank never aliases the read bank while tbl_cnt <= 1, since wr_bank != rd_bank whenever tbl_cnt = 1.
- Reset mid-table: the partial table is discarded and the encoder sees tbl_vld = 0.

Optional Feature:
- Macro: CR_HUF_COMP_LUT_PARITY_EN.
- When defined:
  - Each entry stores an extra even-parity bit computed on write.
  - On a valid read, parity is checked, and output lut_enc_par_err (1 bit, reset 0) pulses alongside rd_vld on mismatch.
- When undefined:
  - No parity storage.
  - lut_enc_par_err port is absent.

Decomposition:
- Shared package cr_huf_compPKG: LUT bank state enum, the DEPTH/ADDR_W defaults for long and short tables, and a packed lut_meta_t {seq_id, st_size}.
- One sub-module, cr_huf_comp_lut_bank: a single bank of DEPTH x DATA_W registers with a write port and a registered read port (with the optional parity bit).
- It is instantiated twice; the top level holds the pointers, count and error logic.

Test Plan:
- Fill and read: write addrs 0..248 with data = addr ^ 0x5A5, wr_done on addr 248 with seq_id = 3 and size = 0x100.
  - Required: tbl_vld = 1, seq_id = 3, size = 0x100.
  - Reading addr 17 returns 0x5B4 one cycle later.
- Ping-pong full: commit two tables without a release.
  - Required: lut_st_full = 1.
  - A third write is dropped and lut_wr_ovfl_err = 1.
  - After tbl_done, full = 0 and seq_id shows the second table.
- Simultaneous commit and release at tbl_cnt = 1: tbl_cnt stays 1, and reads return data from the newly committed bank.
- Read with no table, and read of addr 249: rd_vld = 0 and lut_rd_err pulses once for each.
- Reset asserted mid-fill after 100 writes: all outputs 0; a subsequent full table behaves as in scenario 1.
- With CR_HUF_COMP_LUT_PARITY_EN: force-flip one stored bit at addr 5, then read addr 5 -> lut_enc_par_err = 1 with rd_vld.

Source files
------------

// File: rtl/cr_huf_comp_pkg.sv
// Shared types for the huffman compressor code LUTs.
// Table depths, table-count state and per-table metadata.
package cr_huf_compPKG;

    localparam int LONG_DEPTH   = 249;
    localparam int LONG_ADDR_W  = 8;
    localparam int SHORT_DEPTH  = 30;
    localparam int SHORT_ADDR_W = 5;
    localparam int LUT_SEQ_W    = 4;
    localparam int LUT_SIZE_W   = 20;

    typedef enum logic [1:0] {
        LUT_EMPTY = 2'd0,
        LUT_ONE   = 2'd1,
        LUT_FULL  = 2'd2
    } lut_st_e;

    typedef struct packed {
        logic [LUT_SEQ_W-1:0]  seq_id;
        logic [LUT_SIZE_W-1:0] st_size;
    } lut_meta_t;

endpackage

// File: rtl/cr_huf_comp_lut_long_bank.sv
// One code LUT bank: write port plus registered read port.
// CR_HUF_COMP_LUT_PARITY_EN adds an even-parity bit per entry.
module cr_huf_comp_lut_bank
    import cr_huf_compPKG::*;
#(
    parameter int DEPTH  = LONG_DEPTH,
    parameter int ADDR_W = LONG_ADDR_W,
    parameter int DATA_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
`ifdef CR_HUF_COMP_LUT_PARITY_EN
    ,output logic             rd_par_err
`endif
);

`ifdef CR_HUF_COMP_LUT_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
`ifdef CR_HUF_COMP_LUT_PARITY_EN
            mem[wr_addr] <= {^wr_data, wr_data};
`else
            mem[wr_addr] <= wr_data;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr][DATA_W-1:0];
        end
    end

`ifdef CR_HUF_COMP_LUT_PARITY_EN
    // Stored word including parity bit must XOR to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_par_err <= 1'b0;
        end else begin
            rd_par_err <= rd_en & (^mem[rd_addr]);
        end
    end
`endif

endmodule

// File: rtl/cr_huf_comp_lut_long.sv
// Ping-pong code LUT between the long table builder and encoder.
// Optional CR_HUF_COMP_LUT_PARITY_EN adds lut_enc_par_err.
module cr_huf_comp_lut_long
    import cr_huf_compPKG::*;
#(
    parameter int DEPTH  = LONG_DEPTH,
    parameter int ADDR_W = LONG_ADDR_W,
    parameter int DATA_W = 20,
    parameter int SEQ_W  = LUT_SEQ_W,
    parameter int SIZE_W = LUT_SIZE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_lut_wr,
    input  logic [ADDR_W-1:0] st_lut_wr_addr,
    input  logic [DATA_W-1:0] st_lut_wr_data,
    input  logic              st_lut_wr_done,
    input  logic [SEQ_W-1:0]  st_lut_seq_id,
    input  logic [SIZE_W-1:0] st_lut_st_size,
    output logic              lut_st_full,
    input  logic              enc_lut_rd,
    input  logic [ADDR_W-1:0] enc_lut_rd_addr,
    input  logic              enc_lut_tbl_done,
    output logic              lut_enc_rd_vld,
    output logic [DATA_W-1:0] lut_enc_rd_data,
    output logic              lut_enc_tbl_vld,
    output logic [SEQ_W-1:0]  lut_enc_seq_id,
    output logic [SIZE_W-1:0] lut_enc_st_size,
    output logic              lut_wr_ovfl_err,
    output logic              lut_rd_err
`ifdef CR_HUF_COMP_LUT_PARITY_EN
    ,output logic             lut_enc_par_err
`endif
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    lut_st_e   cnt_q, cnt_d;
    logic      wr_bank_q, rd_bank_q, rd_sel_q;
    lut_meta_t meta_q [2];

    logic wr_in_rng, rd_in_rng;
    logic wr_ok, commit, release_tbl, rd_ok;

    logic [DATA_W-1:0] bank_rd_data [2];
`ifdef CR_HUF_COMP_LUT_PARITY_EN
    logic [1:0] bank_par_err;
`endif

    assign lut_st_full     = (cnt_q == LUT_FULL);
    assign lut_enc_tbl_vld = (cnt_q != LUT_EMPTY);

    assign wr_in_rng   = {1'b0, st_lut_wr_addr} < DEPTH_C;
    assign rd_in_rng   = {1'b0, enc_lut_rd_addr} < DEPTH_C;
    assign wr_ok       = st_lut_wr & ~lut_st_full & wr_in_rng;
    assign commit      = wr_ok & st_lut_wr_done;
    assign release_tbl = enc_lut_tbl_done & lut_enc_tbl_vld;
    assign rd_ok       = enc_lut_rd & lut_enc_tbl_vld & rd_in_rng;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({commit, release_tbl})
            2'b10:   cnt_d = (cnt_q == LUT_EMPTY) ? LUT_ONE : LUT_FULL;
            2'b01:   cnt_d = (cnt_q == LUT_FULL) ? LUT_ONE : LUT_EMPTY;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q           <= LUT_EMPTY;
            wr_bank_q       <= 1'b0;
            rd_bank_q       <= 1'b0;
            rd_sel_q        <= 1'b0;
            meta_q[0]       <= '0;
            meta_q[1]       <= '0;
            lut_wr_ovfl_err <= 1'b0;
            lut_rd_err      <= 1'b0;
            lut_enc_rd_vld  <= 1'b0;
        end else begin
            cnt_d_apply: begin
                cnt_q <= cnt_d;
            end
            if (commit) begin
                meta_q[wr_bank_q] <= '{seq_id: st_lut_seq_id,
                                       st_size: st_lut_st_size};
                wr_bank_q <= ~wr_bank_q;
            end
            if (release_tbl) begin
                rd_bank_q <= ~rd_bank_q;
            end
            if (rd_ok) begin
                rd_sel_q <= rd_bank_q;
            end
            if (st_lut_wr & ~wr_ok) begin
                lut_wr_ovfl_err <= 1'b1;
            end
            lut_rd_err     <= enc_lut_rd & ~rd_ok;
            lut_enc_rd_vld <= rd_ok;
        end
    end

    assign lut_enc_seq_id  = lut_enc_tbl_vld ? meta_q[rd_bank_q].seq_id : '0;
    assign lut_enc_st_size = lut_enc_tbl_vld ? meta_q[rd_bank_q].st_size : '0;
    assign lut_enc_rd_data = bank_rd_data[rd_sel_q];
`ifdef CR_HUF_COMP_LUT_PARITY_EN
    assign lut_enc_par_err = lut_enc_rd_vld & bank_par_err[rd_sel_q];
`endif

    for (genvar b = 0; b < 2; b++) begin : g_bank
        cr_huf_comp_lut_bank #(
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en      (wr_ok & (wr_bank_q == 1'(b))),
            .wr_addr    (st_lut_wr_addr),
            .wr_data    (st_lut_wr_data),
            .rd_en      (rd_ok & (rd_bank_q == 1'(b))),
            .rd_addr    (enc_lut_rd_addr),
            .rd_data    (bank_rd_data[b])
`ifdef CR_HUF_COMP_LUT_PARITY_EN
            ,.rd_par_err (bank_par_err[b])
`endif
        );
    end

endmodule
